// File: rtl/spi_master_burst.sv
// spi_master_burst: parametrised SPI master with chip-select sequencing
// and multi-word bursts between a TX/RX word front end and SPI pins.
//
// Ports:
//   i_Clk, i_Rst_L        system clock, async active-low reset
//   i_TX_DV, i_TX_Word    word handshake, taken when o_TX_Ready=1
//   i_TX_Count, i_CS_Sel  burst length / target CS, first word only
//   i_Abort               synchronous burst abort
//   o_TX_Ready, o_Busy    front-end status
//   o_RX_DV, o_RX_Word    received word, one-cycle strobe
//   o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO, o_SPI_CS_n   SPI pins
module spi_master_burst #(
    parameter int SPI_MODE          = 0,
    parameter int LSB_FIRST         = 0,
    parameter int WORD_W            = 8,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int NUM_CS            = 1,
    parameter int MAX_WORDS         = 16,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_HOLD_CLKS      = 2,
    parameter int CS_IDLE_CLKS      = 2
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst_L,
    input  logic                               i_TX_DV,
    input  logic [WORD_W-1:0]                  i_TX_Word,
    input  logic [$clog2(MAX_WORDS+1)-1:0]     i_TX_Count,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] i_CS_Sel,
    input  logic                               i_Abort,
    output logic                               o_TX_Ready,
    output logic                               o_Busy,
    output logic                               o_RX_DV,
    output logic [WORD_W-1:0]                  o_RX_Word,
    output logic                               o_SPI_Clk,
    input  logic                               i_SPI_MISO,
    output logic                               o_SPI_MOSI,
    output logic [NUM_CS-1:0]                  o_SPI_CS_n
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int EW = $clog2(2 * WORD_W + 1);
    localparam int HW = $clog2(CLKS_PER_HALF_BIT);
    localparam int WAIT_MAX =
        (CS_SETUP_CLKS > CS_HOLD_CLKS) ?
        ((CS_SETUP_CLKS > CS_IDLE_CLKS) ? CS_SETUP_CLKS : CS_IDLE_CLKS) :
        ((CS_HOLD_CLKS > CS_IDLE_CLKS) ? CS_HOLD_CLKS : CS_IDLE_CLKS);
    localparam int TW = $clog2(WAIT_MAX + 1);

    localparam logic CPOL = ((SPI_MODE / 2) % 2) != 0;
    localparam logic CPHA = (SPI_MODE % 2) != 0;
    localparam logic LSBF = LSB_FIRST != 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_XFER,
        S_WAIT_NEXT,
        S_CS_HOLD,
        S_CS_GAP
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_ready;
    logic                r_rx_dv;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;
    logic [WORD_W-1:0]   r_tx;
    logic [WORD_W-1:0]   r_rx;
    logic [WORD_W-1:0]   r_rx_word;
    logic [CW-1:0]       r_remain;
    logic [EW-1:0]       r_edges;
    logic [HW-1:0]       r_half;
    logic [TW-1:0]       r_cnt;

    logic                w_abort;
    logic                w_accept;
    logic                w_word_done;
    logic                w_tick;
    logic                w_lead;
    logic [WORD_W-1:0]   w_tx_shift;
    logic [WORD_W-1:0]   w_rx_shift;
    logic [CW-1:0]       w_count;
    logic [NUM_CS-1:0]   w_cs_n;

    function automatic logic f_first(input logic [WORD_W-1:0] w);
        return LSBF ? w[0] : w[WORD_W-1];
    endfunction

    // Abort is meaningless in IDLE, so a DV there still goes through.
    assign w_abort     = i_Abort && (r_state != S_IDLE);
    assign w_accept    = i_TX_DV && r_ready && !w_abort;
    assign w_word_done = (r_state == S_XFER) &&
                         (r_edges == EW'(2 * WORD_W));
    assign w_tick      = (r_state == S_XFER) && !w_word_done &&
                         (r_half == HW'(CLKS_PER_HALF_BIT - 1));
    // Even edge index = leading edge of the bit.
    assign w_lead      = ~r_edges[0];

    assign w_tx_shift = LSBF ? (r_tx >> 1) : (r_tx << 1);
    assign w_rx_shift = LSBF ? {i_SPI_MISO, r_rx[WORD_W-1:1]}
                             : {r_rx[WORD_W-2:0], i_SPI_MISO};

    always_comb begin
        w_count = i_TX_Count;
        if (i_TX_Count == '0)
            w_count = CW'(1);
        else if (32'(i_TX_Count) > 32'(MAX_WORDS))
            w_count = CW'(MAX_WORDS);
    end

    always_comb begin
        w_cs_n = ~(NUM_CS'(1) << i_CS_Sel);
        if (32'(i_CS_Sel) >= 32'(NUM_CS))
            w_cs_n = ~NUM_CS'(1);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept) w_next = S_CS_SETUP;
            S_CS_SETUP:
                if (r_cnt == TW'(CS_SETUP_CLKS - 1)) w_next = S_XFER;
            S_XFER:
                if (w_word_done)
                    w_next = (r_remain == CW'(1)) ? S_CS_HOLD
                                                  : S_WAIT_NEXT;
            S_WAIT_NEXT:
                if (w_accept) w_next = S_XFER;
            S_CS_HOLD:
                if (r_cnt == TW'(CS_HOLD_CLKS - 1)) w_next = S_CS_GAP;
            S_CS_GAP:
                if (r_cnt == TW'(CS_IDLE_CLKS - 1)) w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_CS_GAP;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_ready   <= 1'b0;
            r_rx_dv   <= 1'b0;
            r_sclk    <= CPOL;
            r_mosi    <= 1'b0;
            r_cs_n    <= '1;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_word <= '0;
            r_remain  <= '0;
            r_edges   <= '0;
            r_half    <= '0;
            r_cnt     <= '0;
        end else begin
            r_ready <= (w_next == S_IDLE) || (w_next == S_WAIT_NEXT);
            r_rx_dv <= 1'b0;

            // Wait counter restarts on every state change and on abort,
            // so an abort during CS_GAP gives a full idle gap again.
            if (w_abort || (w_next != r_state))
                r_cnt <= '0;
            else if (r_state == S_CS_SETUP || r_state == S_CS_HOLD ||
                     r_state == S_CS_GAP)
                r_cnt <= r_cnt + TW'(1);

            if (w_abort) begin
                r_cs_n  <= '1;
                r_sclk  <= CPOL;
                r_half  <= '0;
                r_edges <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_tx     <= i_TX_Word;
                            r_remain <= w_count;
                            r_cs_n   <= w_cs_n;
                        end
                    end
                    S_CS_SETUP: begin
                        if (w_next == S_XFER) begin
                            r_half  <= '0;
                            r_edges <= '0;
                            if (!CPHA) r_mosi <= f_first(r_tx);
                        end
                    end
                    S_XFER: begin
                        if (w_word_done) begin
                            r_rx_dv   <= 1'b1;
                            r_rx_word <= r_rx;
                            r_remain  <= r_remain - CW'(1);
                        end else if (w_tick) begin
                            r_half  <= '0;
                            r_edges <= r_edges + EW'(1);
                            r_sclk  <= ~r_sclk;
                            if (w_lead) begin
                                if (CPHA) begin
                                    r_mosi <= f_first(r_tx);
                                    r_tx   <= w_tx_shift;
                                end else begin
                                    r_rx <= w_rx_shift;
                                end
                            end else begin
                                if (CPHA) begin
                                    r_rx <= w_rx_shift;
                                end else if (r_edges !=
                                             EW'(2 * WORD_W - 1)) begin
                                    // CPHA=0 already drove bit 0 on entry;
                                    // the final trailing edge has no bit.
                                    r_mosi <= f_first(w_tx_shift);
                                    r_tx   <= w_tx_shift;
                                end
                            end
                        end else begin
                            r_half <= r_half + HW'(1);
                        end
                    end
                    S_WAIT_NEXT: begin
                        if (w_accept) begin
                            r_tx    <= i_TX_Word;
                            r_half  <= '0;
                            r_edges <= '0;
                            if (!CPHA) r_mosi <= f_first(i_TX_Word);
                        end
                    end
                    S_CS_HOLD: begin
                        if (w_next == S_CS_GAP) r_cs_n <= '1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_TX_Ready = r_ready;
    assign o_Busy     = (r_state != S_IDLE);
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Word  = r_rx_word;
    assign o_SPI_Clk  = r_sclk;
    assign o_SPI_MOSI = r_mosi;
    assign o_SPI_CS_n = r_cs_n;

endmodule
